// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and default sizing for the UART TX scheduler.
// Holds the scheduler FSM state encoding and default parameter values.
package uart_sched_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_BUSY_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/UART-facing bundle of the TX scheduler.
// master = requesters plus UART model, slave = scheduler.
interface uart_tx_scheduler_if
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [IDX_W-1:0]          active_id;
  logic                      idle;
  logic                      timeout_err;

  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_start, tx_data, active_id, idle, timeout_err
  );

  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_start, tx_data, active_id, idle, timeout_err
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or above
// the pointer, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_grant_valid,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0] w_cand [NUM_REQ];

  // w_cand[k] is the requester examined k-th, i.e. (ptr + k) mod NUM_REQ
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
    logic [IDX_W:0] w_sum;
    assign w_sum      = {1'b0, i_rr_ptr} + (IDX_W+1)'(g);
    assign w_cand[g]  = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                        IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
  end

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin owner of the single UART transmitter: pick, pulse start, track busy.
// Build macro UART_SCHED_TIMEOUT_EN adds a WAIT_BUSY watchdog with sticky timeout_err.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
`ifdef UART_SCHED_TIMEOUT_EN
  , parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_tx_scheduler_if.slave  io_sched
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t      r_state;
  sched_state_t      w_next_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_active_id;
  logic [DATA_W-1:0] r_tx_data;
  logic              w_grant_valid;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [IDX_W-1:0]  w_ptr_next;
  logic              w_launch;
  logic              w_wd_expire;
  logic [DATA_W-1:0] w_req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_req_byte[g] = io_sched.req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req         (io_sched.req),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // A UART still busy from before our reset blocks arbitration.
  assign w_launch   = (r_state == IDLE) && !io_sched.tx_busy && w_grant_valid;
  assign w_ptr_next = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:      if (w_launch)              w_next_state = LAUNCH;
      LAUNCH:                               w_next_state = WAIT_BUSY;
      WAIT_BUSY: if (io_sched.tx_busy)      w_next_state = WAIT_DONE;
                 else if (w_wd_expire)      w_next_state = IDLE;
      WAIT_DONE: if (!io_sched.tx_busy)     w_next_state = IDLE;
      default:                              w_next_state = IDLE;
    endcase
  end

  always_comb begin
    io_sched.tx_start = (r_state == LAUNCH);
    io_sched.idle     = (r_state == IDLE);
    io_sched.ack      = '0;
    if (r_state == LAUNCH) io_sched.ack[r_active_id] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_data   <= '0;
      r_active_id <= '0;
      r_rr_ptr    <= '0;
    end else if (w_launch) begin
      r_tx_data   <= w_req_byte[w_grant_idx];
      r_active_id <= w_grant_idx;
      r_rr_ptr    <= w_ptr_next;
    end
  end

  assign io_sched.tx_data   = r_tx_data;
  assign io_sched.active_id = r_active_id;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(BUSY_TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;

  // Count value k means k full WAIT_BUSY cycles have already elapsed.
  assign w_wd_expire = (r_state == WAIT_BUSY) && !io_sched.tx_busy &&
                       (r_wd_cnt == WD_W'(BUSY_TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != WAIT_BUSY) r_wd_cnt <= '0;
      else                      r_wd_cnt <= r_wd_cnt + WD_W'(1);
      if (w_wd_expire) r_timeout_err <= 1'b1;
    end
  end

  assign io_sched.timeout_err = r_timeout_err;
`else
  assign w_wd_expire          = 1'b0;
  assign io_sched.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: random requester bytes and UART
// timing, expectations from a round-robin reference model.
module tb_uart_tx_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(N), .DATA_W(W)) sif ();

  bit       uart_auto = 1'b0;
  logic     auto_busy = 1'b0;
  logic     man_busy  = 1'b0;
  int       uart_lat  = 1;
  int       uart_len  = 4;
  int       u_phase   = 0;
  int       u_cnt     = 0;
  assign sif.tx_busy = uart_auto ? auto_busy : man_busy;

`ifdef UART_SCHED_TIMEOUT_EN
  uart_tx_scheduler #(.NUM_REQ(N), .DATA_W(W), .BUSY_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .io_sched(sif.slave));
`else
  uart_tx_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .i_clk(clk), .i_rst(rst), .io_sched(sif.slave));
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_ptr = 0;
  int hold_viol = 0;
  int stray_ack = 0;
  logic [W-1:0] last_data = '0;
  int           last_id   = 0;
  logic [W-1:0] bytes [N];

  // UART model: busy rises uart_lat cycles after tx_start, stays uart_len cycles.
  always begin
    @(posedge clk); #1;
    if (rst || !uart_auto) begin
      u_phase = 0; auto_busy = 1'b0;
    end else if (u_phase == 0) begin
      if (sif.tx_start === 1'b1) begin u_cnt = uart_lat; u_phase = 1; end
    end else if (u_phase == 1) begin
      u_cnt--;
      if (u_cnt == 0) begin auto_busy = 1'b1; u_cnt = uart_len; u_phase = 2; end
    end else begin
      u_cnt--;
      if (u_cnt == 0) begin auto_busy = 1'b0; u_phase = 0; end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) sif.req_data[i*W +: W] = bytes[i];
  endtask

  task automatic do_reset();
    sif.req = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_ptr = 0; last_data = '0; last_id = 0;
  endtask

  // Advances until the next tx_start (bounded); returns what was launched
  // and the request vector present at the arbitration edge.
  task automatic wait_launch(input int budget, output bit got, output int id,
                             output logic [W-1:0] data, output logic [N-1:0] ackv,
                             output logic [N-1:0] pend, output int at_cyc);
    got = 1'b0; id = 0; data = '0; ackv = '0; pend = '0; at_cyc = 0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (sif.tx_start === 1'b1) begin
        got = 1'b1; id = int'(sif.active_id); data = sif.tx_data;
        ackv = sif.ack; pend = sif.req; at_cyc = cyc;
        last_data = sif.tx_data; last_id = int'(sif.active_id);
      end else begin
        if (sif.ack !== '0) stray_ack++;
        if (!sif.idle && (sif.tx_data !== last_data || int'(sif.active_id) != last_id))
          hold_viol++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    total++; if (sif.idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", sif.idle); end
    total++; if (sif.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", sif.tx_start); end
    total++; if (sif.ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", sif.ack); end
    total++; if (sif.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", sif.tx_data); end
    total++; if (sif.active_id !== 2'd0) begin bad++; $display("FAIL reset_active_id got=%0d want=0", sif.active_id); end
    total++; if (sif.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b want=0", sif.timeout_err); end
    do_reset();
  endtask

  task automatic test_single();
    bit got; int id, at, n, exp; logic [W-1:0] d; logic [N-1:0] a, p;
    do_reset();
    uart_auto = 1'b1; uart_lat = 2; uart_len = 100;
    for (int i = 0; i < N; i++) bytes[i] = W'($urandom);
    bytes[2] = 8'hA5; drive_data();
    sif.req = 4'b0100;
    wait_launch(5, got, id, d, a, p, at);
    exp = rr_pick(4'b0100, model_ptr);
    sif.req = '0;
    total++; if (!got || id != exp) begin bad++; $display("FAIL single_id got=%0d want=%0d launched=%0d", id, exp, got); end
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", d); end
    total++; if (a !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b want=0100", a); end
    model_ptr = (exp + 1) % N;
    n = 0;
    while (sif.idle !== 1'b1 && n < 200) begin tick(); n++; end
    total++; if (n != uart_lat + uart_len + 1) begin bad++; $display("FAIL single_idle_cycles got=%0d want=%0d", n, uart_lat + uart_len + 1); end
    wait_launch(10, got, id, d, a, p, at);
    total++; if (got) begin bad++; $display("FAIL single_extra_launch got=1 want=0"); end
  endtask

  task automatic test_round_robin();
    bit got; int id, at, prev_at, exp; logic [W-1:0] d; logic [N-1:0] a, p;
    do_reset();
    uart_auto = 1'b1;
    uart_lat = int'($urandom_range(1, 3)); uart_len = int'($urandom_range(4, 12));
    hold_viol = 0; stray_ack = 0; prev_at = 0;
    for (int i = 0; i < N; i++) bytes[i] = W'($urandom);
    drive_data();
    sif.req = 4'b1111;
    for (int f = 0; f < 12; f++) begin
      wait_launch(60, got, id, d, a, p, at);
      exp = rr_pick(p, model_ptr);
      total++; if (!got || id != exp || id != f % N) begin bad++; $display("FAIL rr_id frame=%0d got=%0d want=%0d", f, id, exp); end
      total++; if (got && exp >= 0 && (d !== bytes[exp] || a !== (4'b0001 << exp))) begin
        bad++; $display("FAIL rr_data_ack frame=%0d data=%h want=%h ack=%b", f, d, bytes[exp], a); end
      if (f > 0) begin
        total++; if (at - prev_at != uart_lat + uart_len + 2) begin
          bad++; $display("FAIL rr_gap frame=%0d got=%0d want=%0d", f, at - prev_at, uart_lat + uart_len + 2); end
      end
      prev_at = at;
      if (exp >= 0) begin bytes[exp] = W'($urandom); model_ptr = (exp + 1) % N; end
      drive_data();
    end
    sif.req = '0;
    total++; if (hold_viol != 0) begin bad++; $display("FAIL rr_hold got=%0d want=0", hold_viol); end
    total++; if (stray_ack != 0) begin bad++; $display("FAIL rr_stray_ack got=%0d want=0", stray_ack); end
  endtask

  task automatic test_fairness();
    bit got; int id, at, exp; logic [W-1:0] d; logic [N-1:0] a, p;
    int seq [4] = '{0, 0, 3, 0};
    do_reset();
    uart_auto = 1'b1; uart_lat = 1; uart_len = 6;
    for (int i = 0; i < N; i++) bytes[i] = W'($urandom);
    drive_data();
    sif.req = 4'b0001;
    for (int f = 0; f < 4; f++) begin
      wait_launch(40, got, id, d, a, p, at);
      exp = rr_pick(p, model_ptr);
      total++; if (!got || id != seq[f] || id != exp) begin bad++; $display("FAIL fair_id frame=%0d got=%0d want=%0d", f, id, seq[f]); end
      total++; if (d !== bytes[seq[f]]) begin bad++; $display("FAIL fair_data frame=%0d got=%h want=%h", f, d, bytes[seq[f]]); end
      model_ptr = (id + 1) % N;
      bytes[id] = W'($urandom);
      if (id == 3) sif.req[3] = 1'b0;
      if (f == 1) sif.req[3] = 1'b1;
      drive_data();
    end
    sif.req = '0;
  endtask

  task automatic test_rearm();
    bit got; int id, at; logic [W-1:0] d; logic [N-1:0] a, p;
    int           ids  [3] = '{0, 2, 0};
    logic [W-1:0] dats [3] = '{8'h11, 8'h22, 8'h3C};
    do_reset();
    uart_auto = 1'b1; uart_lat = 1; uart_len = 5;
    for (int i = 0; i < N; i++) bytes[i] = W'($urandom);
    bytes[0] = 8'h11; bytes[2] = 8'h22; drive_data();
    sif.req = 4'b0101;
    for (int f = 0; f < 3; f++) begin
      wait_launch(40, got, id, d, a, p, at);
      total++; if (!got || id != ids[f] || d !== dats[f]) begin
        bad++; $display("FAIL rearm frame=%0d id=%0d want=%0d data=%h want=%h", f, id, ids[f], d, dats[f]); end
      if (f == 0) bytes[0] = 8'h3C;
      if (f == 1) sif.req[2] = 1'b0;
      if (f == 2) sif.req[0] = 1'b0;
      drive_data();
    end
    wait_launch(40, got, id, d, a, p, at);
    total++; if (got) begin bad++; $display("FAIL rearm_extra got=1 id=%0d want=none", id); end
  endtask

  task automatic test_mid_reset();
    bit got; int id, at, n, viol; logic [W-1:0] d; logic [N-1:0] a, p;
    do_reset();
    uart_auto = 1'b1; uart_lat = 1; uart_len = 30;
    bytes[0] = W'($urandom); drive_data();
    sif.req = 4'b0001;
    wait_launch(5, got, id, d, a, p, at);
    n = 0;
    while (sif.tx_busy !== 1'b1 && n < 10) begin tick(); n++; end
    repeat (3) tick();
    man_busy = 1'b1; uart_auto = 1'b0;
    rst = 1'b1; #1;
    total++; if (sif.idle !== 1'b1 || sif.tx_start !== 1'b0 || sif.ack !== 4'b0000) begin
      bad++; $display("FAIL midrst_ctrl idle=%b start=%b ack=%b want 1/0/0000", sif.idle, sif.tx_start, sif.ack); end
    total++; if (sif.tx_data !== 8'h00 || sif.active_id !== 2'd0) begin
      bad++; $display("FAIL midrst_regs data=%h id=%0d want 00/0", sif.tx_data, sif.active_id); end
    tick();
    rst = 1'b0; model_ptr = 0; last_data = '0; last_id = 0;
    viol = 0;
    repeat (10) begin tick(); if (sif.tx_start !== 1'b0 || sif.idle !== 1'b1) viol++; end
    total++; if (viol != 0) begin bad++; $display("FAIL midrst_hold got=%0d want=0", viol); end
    man_busy = 1'b0;
    wait_launch(3, got, id, d, a, p, at);
    sif.req = '0;
    total++; if (!got || id != rr_pick(4'b0001, model_ptr) || d !== bytes[0]) begin
      bad++; $display("FAIL midrst_relaunch id=%0d data=%h want 0/%h launched=%0d", id, d, bytes[0], got); end
    model_ptr = 1;
    man_busy = 1'b1; repeat (2) tick();
    man_busy = 1'b0; repeat (2) tick();
    total++; if (sif.idle !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b want=1", sif.idle); end
  endtask

  task automatic test_stuck_busy();
    bit got; int id, at, viol, first; logic idle_at; logic [W-1:0] d; logic [N-1:0] a, p;
    do_reset();
    uart_auto = 1'b0; man_busy = 1'b0;
    bytes[1] = W'($urandom); drive_data();
    sif.req = 4'b0010;
    wait_launch(5, got, id, d, a, p, at);
    sif.req = '0;
    viol = 0; first = 0; idle_at = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (sif.tx_start !== 1'b0) viol++;
`ifdef UART_SCHED_TIMEOUT_EN
      if (sif.timeout_err === 1'b1 && first == 0) begin first = t; idle_at = sif.idle; end
`else
      if (sif.idle !== 1'b0 || sif.timeout_err !== 1'b0) viol++;
`endif
    end
`ifdef UART_SCHED_TIMEOUT_EN
    total++; if (first != 17 || idle_at !== 1'b1) begin bad++; $display("FAIL wd_timeout at=%0d want=17 idle=%b", first, idle_at); end
`endif
    total++; if (!got || viol != 0) begin bad++; $display("FAIL stuck_wait viol=%0d want=0 launched=%0d", viol, got); end
    man_busy = 1'b1; tick();
    man_busy = 1'b0; tick();
    total++; if (sif.idle !== 1'b1) begin bad++; $display("FAIL stuck_release idle=%b want=1", sif.idle); end
  endtask

  initial begin
    rst = 1'b1;
    sif.req = '0;
    sif.req_data = '0;
    for (int i = 0; i < N; i++) bytes[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_rearm();
    test_mid_reset();
    test_stuck_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter between several byte producers (status reporter, loopback echo, debug console). It sits between the requesters and the UART TX port (TXstart / TX_data_in / TXbusy). It picks one pending requester, launches its byte with a single-cycle start pulse, then tracks the transmitter's busy flag until the frame completes. Grants rotate fairly across requesters.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width, matches UART data width
- BUSY_TIMEOUT, 1023, max cycles allowed from tx_start to tx_busy rising (used only with watchdog enabled)
- clock  input  1  system clock; all logic rising-edge
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester "byte pending"; level, held until acked
- req_data  input  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
- ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted
- tx_start  output  1  one-cycle start pulse to UART TXstart
- tx_data  output  DATA_W  byte to UART TX_data_in; held stable from launch until frame done
- tx_busy  input  1  UART TXbusy
- active_id  output  $clog2(NUM_REQ)  index of requester owning the transmitter
- idle  output  1  high in IDLE state
- timeout_err  output  1  sticky watchdog flag (watchdog build only; tied 0 otherwise)

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: arbitrate only when tx_busy==0 and |req.
  - Winner is the first set req bit scanning upward (with wrap) from rr_ptr.
  - On the clock edge: tx_data<=winner byte, active_id<=winner, rr_ptr<=winner+1 (wraps to 0 past NUM_REQ-1), state->LAUNCH.
  - If tx_busy==1 (e.g. UART still busy after our reset), stay IDLE.
- LAUNCH: tx_start=1 and ack[active_id]=1 for exactly this cycle; ->WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy==1, then ->WAIT_DONE.
- WAIT_DONE: wait for tx_busy==0, then ->IDLE.
- Requester contract:
  - Requester drops req, or updates req_data for its next byte, in the cycle after its ack.
  - A req still high after ack is treated as a new byte.
- Simultaneous requests: only one wins per arbitration. The ack one-hot never has more than one bit set.
- req changes outside IDLE are ignored. req_data is sampled only at the IDLE->LAUNCH edge.
- Reset values: state=IDLE, rr_ptr=0, tx_start=0, ack=0, tx_data=0, active_id=0, idle=1, timeout_err=0.
- Reset mid-frame: all of the above apply immediately, including to an in-flight frame. The byte being sent is not re-issued. The next launch waits until tx_busy reads 0.

## Timing
- Cycle N: IDLE, req[i]=1, tx_busy=0.
- Cycle N+1: tx_start=1, ack[i]=1, tx_data valid.
- WAIT_BUSY tolerates any tx_busy rise latency ≥1 cycle.
- Cycle after tx_busy falls: IDLE. Next launch occurs one cycle later at the earliest.
- Minimum gap between tx_start pulses: frame length + 3 cycles.
- tx_data and active_id are registered and constant from N+1 until return to IDLE.

## Configuration
- UART_SCHED_TIMEOUT_EN defined:
  - A counter starts at 0 on entering WAIT_BUSY.
  - If it reaches BUSY_TIMEOUT with tx_busy still 0: timeout_err<=1 (sticky until reset), state->IDLE, byte dropped (already acked).
- UART_SCHED_TIMEOUT_EN undefined:
  - No counter. WAIT_BUSY waits indefinitely.
  - timeout_err is constant 0.

## Structure
- Package uart_sched_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - default NUM_REQ, DATA_W and BUSY_TIMEOUT constants.
- Sub-module rr_arbiter: combinational rotating-priority picker.
  - Inputs: req, rr_ptr.
  - Outputs: grant_valid, grant_idx.
  - Instantiated once.

## Test plan
- Single request: req=4'b0100, req_data[2]=8'hA5, tx_busy rises 2 cycles after tx_start and falls 100 cycles later.
  - Expect one tx_start with tx_data=8'hA5, ack=4'b0100, active_id=2, idle again 1 cycle after busy falls.
- All four requesting continuously from reset.
  - Expect grant order 0,1,2,3,0,… and exactly one ack per frame.
- Fairness: req[0] held continuously, req[3] asserted later.
  - Expect requester 3 granted within the next arbitration after its assertion.
- Reset asserted during WAIT_DONE with tx_busy=1 and req=4'b0001 held.
  - Expect outputs at reset values and no tx_start until tx_busy=0.
  - Then the launch goes to requester 0.
- Watchdog build (UART_SCHED_TIMEOUT_EN), BUSY_TIMEOUT=16, tx_busy stuck 0.
  - Expect timeout_err=1 exactly 16 cycles into WAIT_BUSY, then return to IDLE.
  - Non-watchdog build: FSM stays in WAIT_BUSY.
- Requester keeps req high after ack with new req_data=8'h3C.
  - Expect a second frame carrying 8'h3C, with other pending requesters granted in between per rotation.
